disp_scan_mux: RTL and testbench
================================

// Module: disp_scan_mux
// PURPOSE
//  Parametrised time-multiplexed display scanner; successor to the 2:1 dispmux.
//  Rotates a digit select across NDIG packed input words at a prescaled rate.
//  For the selected digit it drives the digit data and an active-low one-hot anode.
//  Sits between the display data registers and the seven-segment decoder/pins.
// PARAMETERS
//  NDIG      4      number of digits scanned, >= 2, need not be a power of two
//  DW        4      bits per digit word
//  PRESCALE  50000  CLK cycles per digit slot, >= 2
//  GUARD     4      blanking cycles at slot start; used only with the macro; < PRESCALE
//  SW        $clog2(NDIG)  localparam: select width
// PORTS
//  CLK        in   1        system clock, all logic on rising edge
//  RST        in   1        synchronous reset, active-high
//  EN         in   1        1 = scanning advances, 0 = hold current digit
//  D_IN       in   NDIG*DW  packed digits, digit k = D_IN[k*DW +: DW]
//  BLANK      in   NDIG     1 = digit k is dark: its anode is never asserted
//  D_OUT      out  DW       data of the currently selected digit
//  SEL        out  SW       index of the current digit, 0..NDIG-1
//  AN         out  NDIG     active-low anode enables, at most one bit is 0
//  SCAN_TICK  out  1        one-cycle pulse on the cycle SEL advances
// BEHAVIOUR
//  Interface: one clock (CLK); reset RST is synchronous and active-high.
//  - All outputs are registered.
//  - Reset: cnt=0, SEL=0, D_OUT=0, AN all ones, SCAN_TICK=0.
//  - Reset asserted mid-scan overrides EN and all other inputs on that edge.
//  - Prescaler cnt counts 0..PRESCALE-1 only while EN=1 and RST=0.
//  - When cnt==PRESCALE-1 and EN=1:
//    - cnt wraps to 0.
//    - SEL becomes SEL+1; from NDIG-1 it wraps to 0, so no illegal index.
//    - SCAN_TICK=1 for that one cycle; otherwise SCAN_TICK=0.
//  - EN=0: cnt and SEL hold, SCAN_TICK=0; D_OUT and AN keep tracking inputs.
//    - EN low on the wrap cycle cancels the advance; it happens at the first EN=1 cycle.
//  - D_OUT <= D_IN slice of the next SEL value, so D_OUT changes on the same edge as SEL.
//    - A D_IN change appears on D_OUT one cycle later (1-cycle latency).
//  - AN <= ~(1<<next SEL), or all ones if BLANK[next SEL]=1.
//    - AN follows BLANK with 1-cycle latency.
//  - Simultaneous BLANK and D_IN changes: both apply on the same next edge.
//  - First cycle after reset release: AN = ~1 (digit 0 lit unless BLANK[0]).
// CONFIGURATION
//  DIGIT_GUARD_EN defined:
//    - AN is forced all ones while the next cnt is below GUARD, i.e. for the first
//      GUARD cycles of every slot (anti-ghosting dead time).
//    - SEL, D_OUT and SCAN_TICK timing are unchanged.
//  DIGIT_GUARD_EN undefined: no guard; GUARD is ignored and AN is never forced off.
// TESTING (NDIG=4, DW=4, PRESCALE=4, GUARD=1 unless stated)
//  1. RST=1 for 2 cycles, then EN=1, D_IN=16'h4321 -> in reset AN=4'b1111, SEL=0, D_OUT=0;
//     after release AN=4'b1110, D_OUT=1; SEL then steps 1,2,3,0 every 4 cycles,
//     D_OUT=2,3,4,1, AN=1101,1011,0111,1110, one SCAN_TICK per step.
//  2. NDIG=3, D_IN=12'h321, EN=1 -> SEL sequence 0,1,2,0,... and never 3;
//     AN returns to 3'b110 after SEL=2.
//  3. EN=0 for 10 cycles mid-slot -> SEL, cnt and AN hold and SCAN_TICK stays 0;
//     changing D_IN digit 0 to 9 gives D_OUT=9 one cycle later;
//     with EN=1 again the slot finishes its remaining count.
//  4. BLANK=4'b0100 -> AN=4'b1111 while SEL=2, D_OUT=3 still shown;
//     all other digits are lit normally.
//  5. Assert RST while SEL=2, cnt=2 -> next edge SEL=0, AN=1111, SCAN_TICK=0;
//     first advance is 4 cycles after release.
//  6. DIGIT_GUARD_EN defined -> AN=1111 for the first cycle of each slot,
//     then the one-hot low bit for the remaining 3; SCAN_TICK/SEL timing identical to test 1.

Source files
------------

// File: rtl/disp_scan_mux.sv
// Time-multiplexed display scanner: rotates a digit select across NDIG packed words at a prescaled rate.
// Optional anti-ghosting dead time at the start of every slot is enabled by defining DIGIT_GUARD_EN.
module disp_scan_mux #(
  parameter int NDIG     = 4,
  parameter int DW       = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 4,
  localparam int SW      = $clog2(NDIG)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [NDIG*DW-1:0]   D_IN,
  input  logic [NDIG-1:0]      BLANK,
  output logic [DW-1:0]        D_OUT,
  output logic [SW-1:0]        SEL,
  output logic [NDIG-1:0]      AN,
  output logic                 SCAN_TICK
);

  // GUARD is always below PRESCALE, so the counter width is set by PRESCALE alone.
  localparam int CNT_SPAN = (PRESCALE > GUARD) ? PRESCALE : GUARD + 1;
  localparam int CW       = (CNT_SPAN > 2) ? $clog2(CNT_SPAN) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(NDIG - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic [NDIG-1:0] an_q, an_d;
  logic            tick_q, tick_d;
  logic            wrap;
  logic            blank_sel;

  assign wrap = EN && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    tick_d = 1'b0;
    if (EN) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
    if (wrap) begin
      sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + SW'(1);
      tick_d = 1'b1;
    end
  end

  // Outputs are registered from the next select value so data, anode and SEL change together.
  always_comb begin
    dout_d    = '0;
    blank_sel = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (sel_d == SW'(k)) begin
        dout_d    = D_IN[k*DW +: DW];
        blank_sel = BLANK[k];
      end
    end
  end

  always_comb begin
    an_d = '1;
    if (!blank_sel) begin
      an_d = ~(NDIG'(1) << sel_d);
    end
`ifdef DIGIT_GUARD_EN
    if (cnt_d < CW'(GUARD)) begin
      an_d = '1;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      sel_q  <= '0;
      dout_q <= '0;
      an_q   <= '1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      dout_q <= dout_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign D_OUT     = dout_q;
  assign SEL       = sel_q;
  assign AN        = an_q;
  assign SCAN_TICK = tick_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Bench for disp_scan_mux: a 4-digit instance driven from a vector table and a 3-digit instance
// checked over several rotations.
module tb_disp_scan_mux;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic [15:0] D_IN;
  logic [3:0]  BLANK;
  logic [3:0]  D_OUT;
  logic [1:0]  SEL;
  logic [3:0]  AN;
  logic        SCAN_TICK;

  logic [11:0] d_in3;
  logic [2:0]  blank3;
  logic [3:0]  d_out3;
  logic [1:0]  sel3;
  logic [2:0]  an3;
  logic        tick3;

  int n_checks = 0;
  int n_errors = 0;

  disp_scan_mux #(.NDIG(4), .DW(4), .PRESCALE(4), .GUARD(1)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .D_IN(D_IN), .BLANK(BLANK),
    .D_OUT(D_OUT), .SEL(SEL), .AN(AN), .SCAN_TICK(SCAN_TICK)
  );

  disp_scan_mux #(.NDIG(3), .DW(4), .PRESCALE(4), .GUARD(1)) dut3 (
    .CLK(CLK), .RST(RST), .EN(EN), .D_IN(d_in3), .BLANK(blank3),
    .D_OUT(d_out3), .SEL(sel3), .AN(an3), .SCAN_TICK(tick3)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    RST    = 1'b1;
    EN     = 1'b1;
    D_IN   = 16'h4321;
    BLANK  = 4'b0000;
    d_in3  = 12'h321;
    blank3 = 3'b000;
  end

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] d;
    logic [3:0]  blank;
    logic [1:0]  sel;
    logic [3:0]  dout;
    logic [3:0]  an;
    logic        tick;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic rst, input logic en, input logic [15:0] d, input logic [3:0] blank,
                     input logic [1:0] sel, input logic [3:0] dout, input logic [3:0] an,
                     input logic tick);
    vec_t v;
    v.rst = rst; v.en = en; v.d = d; v.blank = blank;
    v.sel = sel; v.dout = dout; v.an = an; v.tick = tick;
    vec_q.push_back(v);
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge
  task automatic step(input logic rst, input logic en, input logic [15:0] d, input logic [3:0] blank);
    @(negedge CLK);
    RST = rst; EN = en; D_IN = d; BLANK = blank;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // reset for 2 cycles, then a full rotation
    add(1, 1, 16'h4321, 4'b0000, 0, 0, 4'b1111, 0);
    add(1, 1, 16'h4321, 4'b0000, 0, 0, 4'b1111, 0);
    add(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b1110, 0);
    add(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b1110, 0);
    add(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b1110, 0);
    add(0, 1, 16'h4321, 4'b0000, 1, 2, 4'b1101, 1);
    add(0, 1, 16'h4321, 4'b0000, 1, 2, 4'b1101, 0);
    add(0, 1, 16'h4321, 4'b0000, 1, 2, 4'b1101, 0);
    add(0, 1, 16'h4321, 4'b0000, 1, 2, 4'b1101, 0);
    add(0, 1, 16'h4321, 4'b0000, 2, 3, 4'b1011, 1);
    add(0, 1, 16'h4321, 4'b0000, 2, 3, 4'b1011, 0);
    add(0, 1, 16'h4321, 4'b0000, 2, 3, 4'b1011, 0);
    add(0, 1, 16'h4321, 4'b0000, 2, 3, 4'b1011, 0);
    add(0, 1, 16'h4321, 4'b0000, 3, 4, 4'b0111, 1);
    add(0, 1, 16'h4321, 4'b0000, 3, 4, 4'b0111, 0);
    add(0, 1, 16'h4321, 4'b0000, 3, 4, 4'b0111, 0);
    add(0, 1, 16'h4321, 4'b0000, 3, 4, 4'b0111, 0);
    add(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b1110, 1);
    // digit 2 blanked: dark anode but data still shown
    add(0, 1, 16'h4321, 4'b0100, 0, 1, 4'b1110, 0);
    add(0, 1, 16'h4321, 4'b0100, 0, 1, 4'b1110, 0);
    add(0, 1, 16'h4321, 4'b0100, 0, 1, 4'b1110, 0);
    add(0, 1, 16'h4321, 4'b0100, 1, 2, 4'b1101, 1);
    add(0, 1, 16'h4321, 4'b0100, 1, 2, 4'b1101, 0);
    add(0, 1, 16'h4321, 4'b0100, 1, 2, 4'b1101, 0);
    add(0, 1, 16'h4321, 4'b0100, 1, 2, 4'b1101, 0);
    add(0, 1, 16'h4321, 4'b0100, 2, 3, 4'b1111, 1);
    add(0, 1, 16'h4321, 4'b0100, 2, 3, 4'b1111, 0);
    add(0, 1, 16'h4321, 4'b0100, 2, 3, 4'b1111, 0);
    // reset mid-scan at SEL=2, cnt=2, then first advance 4 cycles after release
    add(1, 1, 16'h4321, 4'b0100, 0, 0, 4'b1111, 0);
    add(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b1110, 0);
    add(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b1110, 0);
    add(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b1110, 0);
    add(0, 1, 16'h4321, 4'b0000, 1, 2, 4'b1101, 1);
    // BLANK latency, and BLANK with D_IN changing on the same edge
    add(0, 1, 16'h4321, 4'b0010, 1, 2, 4'b1111, 0);
    add(0, 1, 16'h4321, 4'b0000, 1, 2, 4'b1101, 0);
    add(0, 1, 16'h4351, 4'b0010, 1, 5, 4'b1111, 0);
    add(0, 1, 16'h4321, 4'b0000, 2, 3, 4'b1011, 1);
    add(0, 1, 16'h4321, 4'b0000, 2, 3, 4'b1011, 0);
    add(0, 1, 16'h4321, 4'b0000, 2, 3, 4'b1011, 0);
    add(0, 1, 16'h4321, 4'b0000, 2, 3, 4'b1011, 0);
    add(0, 1, 16'h4321, 4'b0000, 3, 4, 4'b0111, 1);
    add(0, 1, 16'h4321, 4'b0000, 3, 4, 4'b0111, 0);
    add(0, 1, 16'h4321, 4'b0000, 3, 4, 4'b0111, 0);
    add(0, 1, 16'h4321, 4'b0000, 3, 4, 4'b0111, 0);
    add(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b1110, 1);
    add(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b1110, 0);
    add(0, 1, 16'h4321, 4'b0000, 0, 1, 4'b1110, 0);
    // EN low for 10 cycles at SEL=0, cnt=2; digit 0 changes to 9 while held
    for (int i = 0; i < 10; i++) begin
      if (i < 4) add(0, 0, 16'h4321, 4'b0000, 0, 1, 4'b1110, 0);
      else       add(0, 0, 16'h4329, 4'b0000, 0, 9, 4'b1110, 0);
    end
    add(0, 1, 16'h4329, 4'b0000, 0, 9, 4'b1110, 0);
    add(0, 1, 16'h4329, 4'b0000, 1, 2, 4'b1101, 1);
    // EN low exactly on the wrap cycle postpones the advance
    add(0, 1, 16'h4329, 4'b0000, 1, 2, 4'b1101, 0);
    add(0, 1, 16'h4329, 4'b0000, 1, 2, 4'b1101, 0);
    add(0, 1, 16'h4329, 4'b0000, 1, 2, 4'b1101, 0);
    add(0, 0, 16'h4329, 4'b0000, 1, 2, 4'b1101, 0);
    add(0, 0, 16'h4329, 4'b0000, 1, 2, 4'b1101, 0);
    add(0, 1, 16'h4329, 4'b0000, 2, 3, 4'b1011, 1);

    foreach (vec_q[i]) begin
      step(vec_q[i].rst, vec_q[i].en, vec_q[i].d, vec_q[i].blank);
      check("sel",  i, 32'(SEL),       32'(vec_q[i].sel));
      check("dout", i, 32'(D_OUT),     32'(vec_q[i].dout));
      check("an",   i, 32'(AN),        32'(vec_q[i].an));
      check("tick", i, 32'(SCAN_TICK), 32'(vec_q[i].tick));
    end

    // 3-digit instance: SEL 0,1,2,0,... never 3, anode back to 110 after SEL=2
    step(1, 1, 16'h4321, 4'b0000);
    check("sel3_rst", 0, 32'(sel3), 32'd0);
    check("an3_rst",  0, 32'(an3),  32'h7);
    for (int i = 0; i < 26; i++) begin
      int es;
      logic [2:0] ean;
      step(0, 1, 16'h4321, 4'b0000);
      es  = ((i + 1) / 4) % 3;
      ean = 3'b111;
      ean[es] = 1'b0;
      check("sel3",  i, 32'(sel3),   32'(es));
      check("dout3", i, 32'(d_out3), 32'(es + 1));
      check("an3",   i, 32'(an3),    32'(ean));
      check("tick3", i, 32'(tick3),  32'(((i + 1) % 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
